// File: rtl/lp805x_sfrbus_xbar_pkg.sv
// lp805x_sfrbus_xbar_pkg
//  Shared definitions for the SFR bus crossbar.
//  - Read FSM state encoding (IDLE=0, WAIT=1).
//  - Field offsets inside the packed s_req bus
//    {wr_addr, rd_addr, data_in, wr, rd, bit_in, wr_bit, rd_bit}.
package lp805x_sfrbus_xbar_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } xbar_state_t;

  localparam int REQ_RD_BIT   = 0;
  localparam int REQ_WR_BIT   = 1;
  localparam int REQ_BIT_IN   = 2;
  localparam int REQ_RD       = 3;
  localparam int REQ_WR       = 4;
  localparam int REQ_DATA_LSB = 5;

  function automatic int req_rd_addr_lsb(input int dw);
    return dw + 5;
  endfunction

  function automatic int req_wr_addr_lsb(input int aw, input int dw);
    return aw + dw + 5;
  endfunction

endpackage

// File: rtl/lp805x_sfrbus_xbar_decode.sv
// lp805x_sfr_decode
//  Combinational SFR address decoder: address -> one-hot channel select.
//  Channel i hits when (a & MASK_i) == (BASE_i & MASK_i); lowest index wins.
//  In bit mode the low three address bits select a bit within the byte,
//  so they are cleared before comparison.
// Ports
//  addr      in   AW    address to decode
//  bit_mode  in   1     treat addr as a bit address
//  sel       out  NCH   one-hot select, 0 on miss
module lp805x_sfr_decode #(
  parameter int                AW      = 8,
  parameter int                NCH     = 4,
  parameter logic [NCH*AW-1:0] CH_BASE = {NCH{8'h80}},
  parameter logic [NCH*AW-1:0] CH_MASK = {NCH{8'hF8}}
) (
  input  logic [AW-1:0]  addr,
  input  logic           bit_mode,
  output logic [NCH-1:0] sel
);

  logic [AW-1:0] a;
  logic          hit;

  assign a = bit_mode ? {addr[AW-1:3], 3'b000} : addr;

  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!hit && ((a & CH_MASK[i*AW +: AW]) == (CH_BASE[i*AW +: AW] & CH_MASK[i*AW +: AW]))) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lp805x_sfrbus_xbar.sv
// lp805x_sfrbus_xbar
//  SFR bus crossbar between the lp805x core and NCH peripheral SFR blocks.
//  CPU requests are registered onto one shared request bus (s_req) with
//  independent one-hot write/read channel selects. Writes are posted; reads
//  wait for the selected channel's ack (bounded by TMO cycles) and return
//  through a registered response with a one-cycle rd_valid pulse.
// Ports
//  clk, rst                    clock, synchronous active-high reset
//  wr, rd, wr_bit, rd_bit      CPU strobes
//  wr_addr, rd_addr            CPU addresses (AW)
//  data_in, bit_in             CPU write data / bit
//  busy                        read outstanding, CPU inputs ignored
//  data_out, bit_out           captured read data / bit (held)
//  rd_valid, rd_err            response pulse, error on miss or timeout
//  s_req, s_wsel, s_rsel       peripheral request bus and selects
//  s_data, s_bit, s_ack        per-channel read response
module lp805x_sfrbus_xbar
  import lp805x_sfrbus_xbar_pkg::*;
#(
  parameter int                AW      = 8,
  parameter int                DW      = 8,
  parameter int                NCH     = 4,
  parameter logic [NCH*AW-1:0] CH_BASE = {NCH{8'h80}},
  parameter logic [NCH*AW-1:0] CH_MASK = {NCH{8'hF8}},
  parameter int                TMO     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  wr_bit,
  input  logic                  rd_bit,
  input  logic [AW-1:0]         wr_addr,
  input  logic [AW-1:0]         rd_addr,
  input  logic [DW-1:0]         data_in,
  input  logic                  bit_in,
  output logic                  busy,
  output logic [DW-1:0]         data_out,
  output logic                  bit_out,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic [2*AW+DW+4:0]    s_req,
  output logic [NCH-1:0]        s_wsel,
  output logic [NCH-1:0]        s_rsel,
  input  logic [NCH*DW-1:0]     s_data,
  input  logic [NCH-1:0]        s_bit,
  input  logic [NCH-1:0]        s_ack
);

  localparam int CW     = $clog2(TMO + 1);
  localparam int RA_LSB = req_rd_addr_lsb(DW);

  xbar_state_t    state;
  logic [CW-1:0]  cnt;
  logic [NCH-1:0] wsel_d, rsel_d;
  logic [DW-1:0]  ack_data;
  logic           ack_bit;
  logic           ack_hit;

  lp805x_sfr_decode #(.AW(AW), .NCH(NCH), .CH_BASE(CH_BASE), .CH_MASK(CH_MASK)) u_wdec (
    .addr(wr_addr), .bit_mode(wr_bit), .sel(wsel_d)
  );

  lp805x_sfr_decode #(.AW(AW), .NCH(NCH), .CH_BASE(CH_BASE), .CH_MASK(CH_MASK)) u_rdec (
    .addr(rd_addr), .bit_mode(rd_bit), .sel(rsel_d)
  );

  // s_rsel is one-hot, so the mux reduces to picking the selected lane;
  // acks from unselected channels never reach ack_hit.
  always_comb begin
    ack_data = '0;
    ack_bit  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (s_rsel[i]) begin
        ack_data = s_data[i*DW +: DW];
        ack_bit  = s_bit[i];
      end
    end
  end

  assign ack_hit = |(s_ack & s_rsel);
  assign busy    = (state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      s_req    <= '0;
      s_wsel   <= '0;
      s_rsel   <= '0;
      data_out <= '0;
      bit_out  <= 1'b0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      s_wsel   <= '0;
      case (state)
        ST_IDLE: begin
          s_req  <= {wr_addr, rd_addr, data_in, wr, rd, bit_in, wr_bit, rd_bit};
          s_wsel <= (wr | wr_bit) ? wsel_d : '0;
          if (rd | rd_bit) begin
            if (|rsel_d) begin
              state  <= ST_WAIT;
              s_rsel <= rsel_d;
              cnt    <= '0;
            end else begin
              // Read miss answers immediately with an error response.
              data_out <= '1;
              bit_out  <= 1'b1;
              rd_valid <= 1'b1;
              rd_err   <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          // Only the read address stays on the bus; strobes and write fields drop.
          s_req <= {{AW{1'b0}}, s_req[RA_LSB +: AW], {DW{1'b0}}, 5'b0};
          if (ack_hit) begin
            data_out <= ack_data;
            bit_out  <= ack_bit;
            rd_valid <= 1'b1;
            s_rsel   <= '0;
            state    <= ST_IDLE;
          end else if (cnt == CW'(TMO - 1)) begin
            data_out <= '1;
            bit_out  <= 1'b1;
            rd_valid <= 1'b1;
            rd_err   <= 1'b1;
            s_rsel   <= '0;
            state    <= ST_IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lp805x_sfrbus_xbar.sv
// tb_lp805x_sfrbus_xbar
//  Directed-vector bench for the SFR bus crossbar. Channel map:
//  ch0 80/F8, ch1 88/F8, ch2 90/FF (exact byte), ch3 98/F8.
//  ch2's full mask makes byte address 93 miss while bit address 93 hits.
module tb_lp805x_sfrbus_xbar;
  import lp805x_sfrbus_xbar_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int TMO = 15;
  localparam logic [NCH*AW-1:0] BASE = {8'h98, 8'h90, 8'h88, 8'h80};
  localparam logic [NCH*AW-1:0] MASK = {8'hF8, 8'hFF, 8'hF8, 8'hF8};
  localparam int RA_LSB = req_rd_addr_lsb(DW);
  localparam int WA_LSB = req_wr_addr_lsb(AW, DW);

  logic               clk = 1'b0;
  logic               rst;
  logic               wr, rd, wr_bit, rd_bit, bit_in;
  logic [AW-1:0]      wr_addr, rd_addr;
  logic [DW-1:0]      data_in;
  logic               busy, bit_out, rd_valid, rd_err;
  logic [DW-1:0]      data_out;
  logic [2*AW+DW+4:0] s_req;
  logic [NCH-1:0]     s_wsel, s_rsel, s_bit, s_ack;
  logic [NCH*DW-1:0]  s_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lp805x_sfrbus_xbar #(
    .AW(AW), .DW(DW), .NCH(NCH), .CH_BASE(BASE), .CH_MASK(MASK), .TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .wr_bit(wr_bit), .rd_bit(rd_bit),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .data_in(data_in), .bit_in(bit_in),
    .busy(busy), .data_out(data_out), .bit_out(bit_out), .rd_valid(rd_valid),
    .rd_err(rd_err), .s_req(s_req), .s_wsel(s_wsel), .s_rsel(s_rsel),
    .s_data(s_data), .s_bit(s_bit), .s_ack(s_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr = 0; rd = 0; wr_bit = 0; rd_bit = 0; bit_in = 0;
    wr_addr = '0; rd_addr = '0; data_in = '0;
  endtask

  task automatic chk_resp(input string tag, input logic v, input logic e,
                          input logic [DW-1:0] d, input logic b);
    chk({tag, "_valid"}, 64'(rd_valid), 64'(v));
    chk({tag, "_err"},   64'(rd_err),   64'(e));
    chk({tag, "_data"},  64'(data_out), 64'(d));
    chk({tag, "_bit"},   64'(bit_out),  64'(b));
  endtask

  initial begin
    idle_inputs();
    s_data = '0; s_bit = '0; s_ack = '0;
    rst = 1;
    tick(); tick();
    chk("rst_sreq",  64'(s_req),  64'h0);
    chk("rst_wsel",  64'(s_wsel), 64'h0);
    chk("rst_rsel",  64'(s_rsel), 64'h0);
    chk("rst_busy",  64'(busy),   64'h0);
    chk_resp("rst", 0, 0, 8'h00, 0);
    rst = 0;
    tick();

    // 1: posted byte write to ch0, fields valid one cycle
    wr = 1; wr_addr = 8'h81; data_in = 8'h5A;
    tick();
    idle_inputs();
    chk("t1_wsel",  64'(s_wsel), 64'h1);
    chk("t1_data",  64'(s_req[REQ_DATA_LSB +: DW]), 64'h5A);
    chk("t1_wr",    64'(s_req[REQ_WR]), 64'h1);
    chk("t1_waddr", 64'(s_req[WA_LSB +: AW]), 64'h81);
    tick();
    chk("t1_wsel_drop", 64'(s_wsel), 64'h0);
    chk("t1_data_drop", 64'(s_req[REQ_DATA_LSB +: DW]), 64'h0);

    // bit write 93 decodes as 90 -> ch2
    wr_bit = 1; wr_addr = 8'h93; bit_in = 1;
    tick();
    idle_inputs();
    chk("wbit_wsel", 64'(s_wsel), 64'h4);
    chk("wbit_bitin", 64'(s_req[REQ_BIT_IN]), 64'h1);

    // 2: read ch2, ack after 3 wait cycles
    rd = 1; rd_addr = 8'h90;
    tick();                                  // cycle 1
    idle_inputs();
    chk("t2_rsel", 64'(s_rsel), 64'h4);
    chk("t2_busy1", 64'(busy), 64'h1);
    wr = 1; wr_addr = 8'h81; data_in = 8'hEE; // must be ignored in WAIT
    tick();                                  // cycle 2
    idle_inputs();
    chk("t2_busy2", 64'(busy), 64'h1);
    chk("t2_sreq_wait", 64'(s_req), 64'(8'h90) << RA_LSB);
    tick();                                  // cycle 3
    chk("t2_busy3", 64'(busy), 64'h1);
    chk("t2_wsel_ign", 64'(s_wsel), 64'h0);
    tick();                                  // cycle 4
    chk("t2_busy4", 64'(busy), 64'h1);
    chk("t2_novalid4", 64'(rd_valid), 64'h0);
    s_ack = 4'b0100; s_data[2*DW +: DW] = 8'hC3; s_bit = 4'b0000;
    tick();                                  // cycle 5
    s_ack = '0;
    chk_resp("t2", 1, 0, 8'hC3, 0);
    chk("t2_busy5", 64'(busy), 64'h0);
    chk("t2_rsel_clr", 64'(s_rsel), 64'h0);
    tick();
    chk_resp("t2_hold", 0, 0, 8'hC3, 0);

    // 4: read miss at F0
    rd = 1; rd_addr = 8'hF0;
    tick();
    idle_inputs();
    chk_resp("t4", 1, 1, 8'hFF, 1);
    chk("t4_rsel", 64'(s_rsel), 64'h0);
    chk("t4_busy", 64'(busy), 64'h0);

    // 5: rd_bit 93 -> ch2, zero-wait ack
    rd_bit = 1; rd_addr = 8'h93;
    tick();                                  // cycle 1
    idle_inputs();
    chk("t5_rsel", 64'(s_rsel), 64'h4);
    chk("t5_rdbit", 64'(s_req[REQ_RD_BIT]), 64'h1);
    s_ack = 4'b0100; s_bit = 4'b0100; s_data[2*DW +: DW] = 8'h3C;
    tick();                                  // cycle 2
    s_ack = '0; s_bit = '0;
    chk_resp("t5", 1, 0, 8'h3C, 1);

    // byte read 93 misses: ch2 compares all bits
    rd = 1; rd_addr = 8'h93;
    tick();
    idle_inputs();
    chk_resp("rd93", 1, 1, 8'hFF, 1);
    chk("rd93_rsel", 64'(s_rsel), 64'h0);

    // 3: timeout on ch1 while an unselected channel acks
    rd = 1; rd_addr = 8'h88;
    tick();                                  // cycle 1
    idle_inputs();
    chk("t3_rsel", 64'(s_rsel), 64'h2);
    s_ack = 4'b0001; s_data[0 +: DW] = 8'h11;
    for (int c = 2; c <= 15; c++) tick();    // cycle 15
    chk("t3_novalid15", 64'(rd_valid), 64'h0);
    chk("t3_busy15", 64'(busy), 64'h1);
    tick();                                  // cycle 16
    s_ack = '0;
    chk_resp("t3", 1, 1, 8'hFF, 1);
    chk("t3_busy16", 64'(busy), 64'h0);
    tick();
    chk("t3_pulse", 64'(rd_valid), 64'h0);

    // 6: concurrent write ch0 + read ch1, then reset in WAIT
    wr = 1; wr_addr = 8'h82; data_in = 8'hA5;
    rd = 1; rd_addr = 8'h8A;
    tick();
    idle_inputs();
    chk("t6_wsel", 64'(s_wsel), 64'h1);
    chk("t6_rsel", 64'(s_rsel), 64'h2);
    chk("t6_busy", 64'(busy), 64'h1);
    tick();
    rst = 1; s_ack = 4'b0010; s_data[1*DW +: DW] = 8'h77;
    tick();
    chk("t6r_valid", 64'(rd_valid), 64'h0);
    chk("t6r_rsel", 64'(s_rsel), 64'h0);
    chk("t6r_busy", 64'(busy), 64'h0);
    chk("t6r_sreq", 64'(s_req), 64'h0);
    chk("t6r_data", 64'(data_out), 64'h0);
    rst = 0; s_ack = '0;
    tick();
    chk("t6r_after", 64'(rd_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
